periodic_caller: RTL

- Initiator side of the start_port/done_port call handshake used by the Bambu-generated accelerators and the IP-library helpers in the VGA_Nexys4 example.
- Issues one-cycle start pulses to a callee at a programmable period and waits for the callee's done.
- Measures per-call latency, flags period overruns, and aborts on a watchdog timeout.
- Sits between board-level control (switches/frame tick logic) and a callee such as the delay helper or a synthesized top function.

---
 rtl/periodic_caller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/periodic_caller.sv
// Initiator side of a start/done call handshake: issues start pulses at a programmable
// period, measures per-call latency, flags overruns and aborts on a watchdog timeout.
module periodic_caller #(
    parameter int CNT_W  = 32,
    parameter int CALL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  timeout,
    output logic              callee_start,
    input  logic              callee_done,
    output logic              busy,
    output logic [CALL_W-1:0] call_count,
    output logic [CNT_W-1:0]  last_latency,
    output logic [CNT_W-1:0]  max_latency,
    output logic              overrun,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALL  = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CALL_W-1:0] CALL_ONE = CALL_W'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] pcnt_reg;
    logic [CNT_W-1:0] lcnt_reg;
    logic [CNT_W-1:0] p_reg;
    logic [CNT_W-1:0] t_reg;

    logic [CNT_W-1:0] p_eff;
    logic [CNT_W-1:0] p_minus1;
    logic             done_hit;
    logic             wd_hit;
    logic             chain_call;
    logic             gap_end;

    assign p_eff    = (period == '0) ? CNT_ONE : period;
    assign p_minus1 = p_reg - CNT_ONE;
    assign done_hit = (state_reg == WAIT) && callee_done;
    assign wd_hit   = (state_reg == WAIT) && !callee_done && (t_reg != '0) && (lcnt_reg == t_reg);

    // lcnt equals pcnt while waiting, so a call finishing at P-1 or later goes straight
    // back to CALL; that keeps the spacing at exactly P whenever the callee allows it.
    assign chain_call = (lcnt_reg >= p_minus1);
    assign gap_end    = (pcnt_reg >= p_minus1);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (enable) state_next = CALL;
            end
            CALL: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (callee_done) begin
                    if (!enable)         state_next = IDLE;
                    else if (chain_call) state_next = CALL;
                    else                 state_next = GAP;
                end else if (wd_hit) begin
                    state_next = ERROR;
                end
            end
            GAP: begin
                if (!enable)      state_next = IDLE;
                else if (gap_end) state_next = CALL;
            end
            ERROR: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            pcnt_reg     <= '0;
            lcnt_reg     <= '0;
            p_reg        <= '0;
            t_reg        <= '0;
            callee_start <= 1'b0;
            busy         <= 1'b0;
            call_count   <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            callee_start <= (state_next == CALL);
            busy         <= (state_next != IDLE);

            // Both counters saturate so a stuck callee never produces a false match.
            if (state_next == CALL)
                pcnt_reg <= '0;
            else if (pcnt_reg != CNT_MAX)
                pcnt_reg <= pcnt_reg + CNT_ONE;

            if (state_reg == CALL)
                lcnt_reg <= CNT_ONE;
            else if (state_reg == WAIT && lcnt_reg != CNT_MAX)
                lcnt_reg <= lcnt_reg + CNT_ONE;

            if (state_reg == CALL) begin
                p_reg <= p_eff;
                t_reg <= timeout;
            end

            if (done_hit)
                last_latency <= lcnt_reg;

            if (clear) begin
                max_latency <= '0;
                call_count  <= '0;
            end else if (done_hit) begin
                if (lcnt_reg > max_latency)
                    max_latency <= lcnt_reg;
                call_count <= call_count + CALL_ONE;
            end

            // A flag raised in the same cycle as clear survives, so the event is not lost.
            overrun     <= (overrun && !clear) || (done_hit && (lcnt_reg > p_reg));
            timeout_err <= (timeout_err && !clear) || wd_hit;
        end
    end

endmodule
